muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes rs1/rs2 read data (rdata1/rdata2) plus a funct3 op code and destination register.
- Produces a writeback triple (rd, wdata, we) with a valid/ready handshake toward the writeback mux.
- Shift-add multiply and restoring divide, one bit per cycle, to keep area small.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_unit.sv | 99 +++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake between the issue stage, muldiv_unit and the writeback mux.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [4:0]       in_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       out_rd;
    logic [WIDTH-1:0] out_wdata;
    logic             out_we;
    logic             busy;
    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, flush, out_ready,
        input  in_ready, out_valid, out_rd, out_wdata, out_we, busy
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, flush, out_ready,
        output in_ready, out_valid, out_rd, out_wdata, out_we, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring-divide step per cycle.
module muldiv_unit #(parameter int WIDTH = 32) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] hi, lo, dvs;
    logic             neg_q, neg_r, special;
    logic [4:0]       cnt;
    logic             a_sgn, b_sgn, a_neg, b_neg, dz, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, sp_val, diff, quo, rmd, res;
    logic [WIDTH:0]   msum, rsh;
    logic             ge;
    logic [2*WIDTH-1:0] prod;
    assign bus.in_ready = (state == IDLE) && !bus.flush;
    assign bus.busy     = state != IDLE;
    always_comb begin
        a_sgn  = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) || (bus.in_op[2] && !bus.in_op[0]);
        b_sgn  = (bus.in_op == 3'd1) || (bus.in_op[2] && !bus.in_op[0]);
        a_neg  = a_sgn && bus.in_a[WIDTH-1];
        b_neg  = b_sgn && bus.in_b[WIDTH-1];
        a_mag  = a_neg ? -bus.in_a : bus.in_a;
        b_mag  = b_neg ? -bus.in_b : bus.in_b;
        dz     = bus.in_op[2] && (bus.in_b == '0);
        ovf    = bus.in_op[2] && !bus.in_op[0] && (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.in_b);
        sp_val = dz ? (bus.in_op[1] ? bus.in_a : '1) : (bus.in_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
        msum   = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        rsh    = {hi, lo[WIDTH-1]};
        ge     = rsh >= {1'b0, dvs};
        diff   = rsh[WIDTH-1:0] - dvs;
        prod   = neg_q ? -{hi, lo} : {hi, lo};
        quo    = neg_q ? -lo : lo;
        rmd    = neg_r ? -hi : hi;
        res    = special ? lo : !op[2] ? (op == 3'd0 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH])
                                       : (op[1] ? rmd : quo);
    end
    // special-case divides park their final value in lo and pass through FIX unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            op            <= '0;
            hi            <= '0;
            lo            <= '0;
            dvs           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            special       <= 1'b0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_we    <= 1'b0;
            bus.out_rd    <= '0;
            bus.out_wdata <= '0;
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.out_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op         <= bus.in_op;
                    bus.out_rd <= bus.in_rd;
                    cnt        <= '0;
                    special    <= dz || ovf;
                    hi         <= '0;
                    lo         <= (dz || ovf) ? sp_val : a_mag;
                    dvs        <= b_mag;
                    neg_q      <= a_neg ^ b_neg;
                    neg_r      <= a_neg;
                    state      <= (dz || ovf) ? FIX : CALC;
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (!op[2]) begin
                        {hi, lo} <= {msum, lo[WIDTH-1:1]};
                    end else begin
                        hi <= ge ? diff : rsh[WIDTH-1:0];
                        lo <= {lo[WIDTH-2:0], ge};
                    end
                    if (&cnt) state <= FIX;
                end
                FIX: begin
                    bus.out_wdata <= res;
                    bus.out_valid <= 1'b1;
                    bus.out_we    <= bus.out_rd != '0;
                    state         <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.out_we    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written back-pressure, flush and reset sequences.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    muldiv_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t v[16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_op    = 3'($urandom);
        bus.in_rd    = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int elat);
        int lat;
        check({name, " ready"}, 32'(bus.in_ready), 32'd1);
        issue(op, a, b, rd);
        wait_valid(lat);
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " wdata"}, bus.out_wdata, exp);
        check({name, " rd"}, 32'(bus.out_rd), 32'(rd));
        check({name, " we"}, 32'(bus.out_we), 32'(rd != 5'd0));
        pop();
    endtask

    initial begin
        int lat;
        logic ok;
        v[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 33};
        v[1]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 33};
        v[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 33};
        v[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33};
        v[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 33};
        v[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33};
        v[6]  = '{3'd5, 32'd100,      32'd7,        5'd7,  32'd14,       33};
        v[7]  = '{3'd7, 32'd100,      32'd7,        5'd8,  32'd2,        33};
        v[8]  = '{3'd5, 32'd100,      32'd0,        5'd9,  32'hFFFFFFFF, 1};
        v[9]  = '{3'd7, 32'd100,      32'd0,        5'd10, 32'd100,      1};
        v[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1};
        v[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,        1};
        v[12] = '{3'd0, 32'd2,        32'd2,        5'd0,  32'd4,        33};
        v[13] = '{3'd1, 32'hFFFFFFFD, 32'd5,        5'd13, 32'hFFFFFFFF, 33};
        v[14] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 33};
        v[15] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd15, 32'd1,        33};
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.in_rd = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_we", 32'(bus.out_we), 32'd0);
        check("reset out_rd", 32'(bus.out_rd), 32'd0);
        check("reset out_wdata", bus.out_wdata, 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 16; i++)
            run($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].b, v[i].rd, v[i].exp, v[i].lat);

        // back-pressure: result must hold while writeback stalls
        issue(3'd0, 32'd6, 32'd7, 5'd3);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'd33);
        ok = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 3'd0; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_rd = 5'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_wdata !== 32'd42 || bus.in_ready) ok = 1'b0;
        end
        check("bp stable", 32'(ok), 32'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        check("bp release valid", 32'(bus.out_valid), 32'd0);
        check("bp release busy", 32'(bus.busy), 32'd0);
        check("bp release ready", 32'(bus.in_ready), 32'd1);
        run("after bp", 3'd0, 32'd3, 32'd4, 5'd2, 32'd12, 33);

        // flush mid-CALC with a competing request
        issue(3'd0, 32'd9, 32'd9, 5'd5);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 3'd0; bus.in_a = 32'd1; bus.in_b = 32'd1; bus.in_rd = 5'd1;
        check("flush in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        ok = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy) ok = 1'b1;
        end
        check("flush no result", 32'(ok), 32'd0);
        run("after flush", 3'd0, 32'd3, 32'd5, 5'd4, 32'd15, 33);

        // flush beats out_ready in DONE
        issue(3'd5, 32'd5, 32'd0, 5'd6);
        wait_valid(lat);
        check("flush done latency", 32'(lat), 32'd1);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        check("flush done valid", 32'(bus.out_valid), 32'd0);
        check("flush done busy", 32'(bus.busy), 32'd0);

        // reset mid-CALC
        issue(3'd0, 32'd100, 32'd100, 5'd7);
        repeat (5) @(negedge clk);
        check("pre-rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_we", 32'(bus.out_we), 32'd0);
        check("rst out_rd", 32'(bus.out_rd), 32'd0);
        check("rst out_wdata", bus.out_wdata, 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        run("after rst", 3'd5, 32'd1000, 32'd10, 5'd8, 32'd100, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
